// File: rtl/alu4_status_queue_if.sv
// alu4_status_queue_if: producer/consumer handshake bundle for the ALU status queue.
interface alu4_status_queue_if #(parameter int WIDTH = 4);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       op;
   logic [WIDTH-1:0] result;
   logic             n, z, c, v;
   logic             out_valid;
   logic             out_ready;
   logic [2:0]       out_op;
   logic [WIDTH-1:0] out_result;
   logic [3:0]       out_flags;
   modport master (output in_valid, op, result, n, z, c, v, out_ready,
                   input  in_ready, out_valid, out_op, out_result, out_flags);
   modport slave  (input  in_valid, op, result, n, z, c, v, out_ready,
                   output in_ready, out_valid, out_op, out_result, out_flags);
endinterface

// File: rtl/alu4_status_queue.sv
// alu4_status_queue: FIFO of ALU results with flags, head branch-condition decode and sticky C/V.
module alu4_status_queue #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       reset_n,
   alu4_status_queue_if.slave         bus,
   input  logic [2:0]                 cond,
   output logic                       out_cond,
   input  logic                       clr_sticky,
   output logic                       sticky_c,
   output logic                       sticky_v,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);
   localparam int EW = 3 + WIDTH + 4;
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   logic [EW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wr, r_rd;
   logic [AW:0]   r_count;
   logic          r_sc, r_sv;
   logic          w_push, w_pop;
   logic [EW-1:0] w_head;
   logic [7:0]    w_conds;
   assign bus.in_ready  = r_count != FULL;
   assign bus.out_valid = r_count != '0;
   assign w_push = bus.in_valid & bus.in_ready;
   assign w_pop  = bus.out_valid & bus.out_ready;
   assign w_head = r_mem[r_rd];
   assign bus.out_op     = w_head[EW-1 -: 3];
   assign bus.out_result = w_head[4 +: WIDTH];
   assign bus.out_flags  = w_head[3:0];
   // Indexed by cond: {LT, VS, MI, CC, CS, NE, EQ, always}, flags are {n,z,c,v}
   assign w_conds  = {w_head[3] ^ w_head[0], w_head[0], w_head[3], ~w_head[1],
                      w_head[1], ~w_head[2], w_head[2], 1'b1};
   assign out_cond = bus.out_valid & w_conds[cond];
   assign count    = r_count;
   assign sticky_c = r_sc;
   assign sticky_v = r_sv;
   always_ff @(posedge clk)
      if (w_push) r_mem[r_wr] <= {bus.op, bus.result, bus.n, bus.z, bus.c, bus.v};
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
         r_sc    <= 1'b0;
         r_sv    <= 1'b0;
      end else begin
         r_wr    <= r_wr + AW'(w_push);
         r_rd    <= r_rd + AW'(w_pop);
         r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
         r_sc    <= (clr_sticky ? 1'b0 : r_sc) | (w_push & bus.c);
         r_sv    <= (clr_sticky ? 1'b0 : r_sv) | (w_push & bus.v);
      end
endmodule

// File: tb/tb_alu4_status_queue.sv
// tb_alu4_status_queue: directed + random stimulus with a queue-based scoreboard monitor.
module tb_alu4_status_queue;
   localparam int DEPTH = 2;
   typedef struct {logic [2:0] op; logic [3:0] res; logic n, z, c, v;} ent_t;
   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [2:0] cond = '0;
   logic       out_cond, clr_sticky = 1'b0, sticky_c, sticky_v;
   logic [1:0] count;
   int         n_checks = 0, n_fail = 0;
   ent_t       q[$];
   logic       m_sc = 1'b0, m_sv = 1'b0;
   alu4_status_queue_if #(.WIDTH(4)) bus ();
   alu4_status_queue #(.WIDTH(4), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus), .cond(cond), .out_cond(out_cond),
      .clr_sticky(clr_sticky), .sticky_c(sticky_c), .sticky_v(sticky_v), .count(count)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask
   function automatic logic cond_of(input logic [2:0] s, input ent_t e);
      case (s)
         3'd0: return 1'b1;
         3'd1: return e.z;
         3'd2: return !e.z;
         3'd3: return e.c;
         3'd4: return !e.c;
         3'd5: return e.n;
         3'd6: return e.v;
         default: return e.n != e.v;
      endcase
   endfunction
   // Monitor: outputs are checked mid-cycle against the model, then the model
   // applies the transfers the coming rising edge will perform.
   always @(negedge clk) begin
      logic do_push, do_pop;
      ent_t e;
      if (!reset_n) begin
         q.delete();
         m_sc = 1'b0;
         m_sv = 1'b0;
         chk("rst_count", 32'(count), 0);
         chk("rst_out_valid", 32'(bus.out_valid), 0);
         chk("rst_in_ready", 32'(bus.in_ready), 1);
         chk("rst_sticky", {30'd0, sticky_c, sticky_v}, 0);
      end else begin
         chk("count", 32'(count), 32'(q.size()));
         chk("in_ready", 32'(bus.in_ready), 32'(q.size() < DEPTH));
         chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
         chk("sticky_c", 32'(sticky_c), 32'(m_sc));
         chk("sticky_v", 32'(sticky_v), 32'(m_sv));
         chk("out_cond", 32'(out_cond), q.size() != 0 ? 32'(cond_of(cond, q[0])) : 0);
         if (q.size() != 0) begin
            chk("out_op", 32'(bus.out_op), 32'(q[0].op));
            chk("out_result", 32'(bus.out_result), 32'(q[0].res));
            chk("out_flags", 32'(bus.out_flags), {28'd0, q[0].n, q[0].z, q[0].c, q[0].v});
         end
         do_push = bus.in_valid && q.size() < DEPTH;
         do_pop  = bus.out_ready && q.size() != 0;
         m_sc = (clr_sticky ? 1'b0 : m_sc) | (do_push & bus.c);
         m_sv = (clr_sticky ? 1'b0 : m_sv) | (do_push & bus.v);
         if (do_pop) void'(q.pop_front());
         if (do_push) begin
            e.op = bus.op; e.res = bus.result;
            e.n = bus.n; e.z = bus.z; e.c = bus.c; e.v = bus.v;
            q.push_back(e);
         end
      end
   end
   task automatic drv(input logic iv, input logic [2:0] o, input logic [3:0] r,
                      input logic [3:0] f, input logic ordy, input logic [2:0] cd,
                      input logic cl);
      bus.in_valid = iv; bus.op = o; bus.result = r;
      {bus.n, bus.z, bus.c, bus.v} = f;
      bus.out_ready = ordy; cond = cd; clr_sticky = cl;
      @(posedge clk);
      #1;
   endtask
   initial begin
      bus.in_valid = 1'b0; bus.op = '0; bus.result = '0;
      {bus.n, bus.z, bus.c, bus.v} = '0; bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      drv(1, 3'b110, 4'h0, 4'b0110, 1, 3'b001, 0);
      drv(0, 0, 0, 0, 1, 3'b001, 0);
      drv(0, 0, 0, 0, 1, 3'b001, 0);
      drv(1, 3'd1, 4'hA, 4'b1000, 0, 0, 0);
      drv(1, 3'd2, 4'hB, 4'b0100, 0, 0, 0);
      drv(1, 3'd3, 4'hC, 4'b0010, 1, 0, 0);
      drv(0, 0, 0, 0, 1, 0, 0);
      drv(0, 0, 0, 0, 1, 0, 0);
      drv(1, 3'd4, 4'h1, 4'b0000, 0, 3'd2, 0);
      for (int i = 0; i < 8; i++)
         drv(1, 3'(i), 4'(i + 5), 4'(i), 1, 3'(i), 0);
      drv(0, 0, 0, 0, 1, 0, 0);
      drv(1, 0, 4'h2, 4'b0001, 1, 0, 0);
      drv(1, 0, 4'h3, 4'b0001, 1, 0, 1);
      drv(0, 0, 0, 0, 1, 0, 1);
      drv(0, 0, 0, 0, 1, 0, 0);
      drv(1, 3'd5, 4'h8, 4'b1000, 0, 3'b111, 0);
      drv(0, 0, 0, 0, 1, 3'b111, 0);
      drv(1, 3'd5, 4'h9, 4'b1001, 0, 3'b111, 0);
      drv(0, 0, 0, 0, 1, 3'b111, 0);
      drv(0, 0, 0, 0, 1, 3'b000, 0);
      drv(1, 3'd7, 4'hF, 4'b1111, 0, 0, 0);
      drv(1, 3'd6, 4'hE, 4'b0011, 0, 0, 0);
      reset_n = 1'b0;
      @(posedge clk);
      #1 reset_n = 1'b1;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            reset_n = 1'b0;
            @(posedge clk);
            #1 reset_n = 1'b1;
         end
         drv(1'($urandom_range(0, 1)), 3'($urandom), 4'($urandom), 4'($urandom),
             1'($urandom_range(0, 2) != 0), 3'($urandom), 1'($urandom_range(0, 9) == 0));
      end
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
